commit_tracker: RTL and testbench

Retirement tracker at the end of the writeback stage. It accepts one retiring instruction per cycle from the WB pipeline register and emits a registered per-commit record (inst, dnpc, kill, invalid, en) to the instruction-info trace sink. It stops the core cleanly on ebreak, illegal instruction, misaligned next PC or commit starvation. It also keeps retired-instruction and cycle counters for the simulation harness.

---
 rtl/commit_pkg.sv | 25 ++
 rtl/commit_watchdog.sv | 40 ++++
 rtl/commit_tracker.sv | 109 ++++++++++
 tb/tb_commit_tracker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared types and constants for the writeback commit tracker.
// Imported by commit_tracker and commit_watchdog.
package commit_pkg;

    typedef enum logic [1:0] {
        StRun,
        StHaltEbreak,
        StHaltInvalid,
        StHaltHang
    } commit_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] dnpc;
        logic        kill;
        logic        invalid;
    } commit_rec_t;

    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    function automatic logic pc_misaligned(input logic [63:0] pc);
        return (pc[1:0] & PC_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/commit_watchdog.sv
// Commit-starvation watchdog: counts RUN cycles without a commit and flags
// expiry on the cycle that would reach WDOG_LIMIT idle cycles.
module commit_watchdog
    import commit_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 32'd100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    output logic expire
);

    localparam logic [31:0] LastCount = 32'(WDOG_LIMIT - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // A commit in the expiring cycle wins, so clear masks expiry.
    assign expire = tick && !clear && (count_q == LastCount);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/commit_tracker.sv
// Retirement tracker at the end of writeback: emits one registered trace record
// per commit, halts on ebreak / invalid / starvation, and counts commits and cycles.
module commit_tracker
    import commit_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 32'd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_inst,
    input  logic [63:0] wb_next_pc,
    input  logic        wb_ebreak,
    input  logic        wb_illegal,
    output logic [31:0] inst,
    output logic [63:0] dnpc,
    output logic        kill,
    output logic        invalid,
    output logic        en,
    output logic        halted,
    output logic        hang,
    output logic [63:0] retired_count,
    output logic [63:0] cycle_count
);

    commit_state_e state_q, state_d;
    commit_rec_t   rec_q, rec_d;
    logic          en_q, en_d;
    logic [63:0]   retired_q, retired_d;
    logic [63:0]   cycle_q, cycle_d;

    logic in_run;
    logic commit;
    logic wdog_expire;
    logic bad_commit;

    assign in_run     = (state_q == StRun);
    assign wb_ready   = in_run;
    assign commit     = wb_valid && in_run;
    assign bad_commit = wb_illegal || pc_misaligned(wb_next_pc);

    commit_watchdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (in_run),
        .clear (commit),
        .expire(wdog_expire)
    );

    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        en_d      = 1'b0;
        retired_d = retired_q;
        cycle_d   = cycle_q;

        if (in_run) begin
            cycle_d = cycle_q + 64'd1;
            if (commit) begin
                en_d         = 1'b1;
                retired_d    = retired_q + 64'd1;
                rec_d.inst   = wb_inst;
                rec_d.dnpc   = wb_next_pc;
                rec_d.kill   = 1'b0;
                rec_d.invalid = 1'b0;
                // Invalid outranks ebreak.
                if (bad_commit) begin
                    rec_d.invalid = 1'b1;
                    state_d       = StHaltInvalid;
                end else if (wb_ebreak) begin
                    rec_d.kill = 1'b1;
                    state_d    = StHaltEbreak;
                end
            end else if (wdog_expire) begin
                state_d = StHaltHang;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            rec_q     <= '0;
            en_q      <= 1'b0;
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            en_q      <= en_d;
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
        end
    end

    assign inst          = rec_q.inst;
    assign dnpc          = rec_q.dnpc;
    assign kill          = rec_q.kill;
    assign invalid       = rec_q.invalid;
    assign en            = en_q;
    assign halted        = !in_run;
    assign hang          = (state_q == StHaltHang);
    assign retired_count = retired_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Directed self-checking bench for commit_tracker (WDOG_LIMIT = 8).
module tb_commit_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [31:0] wb_inst = '0;
    logic [63:0] wb_next_pc = '0;
    logic        wb_ebreak = 1'b0;
    logic        wb_illegal = 1'b0;
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic        kill;
    logic        invalid;
    logic        en;
    logic        halted;
    logic        hang;
    logic [63:0] retired_count;
    logic [63:0] cycle_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    commit_tracker #(
        .WDOG_LIMIT(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_inst      (wb_inst),
        .wb_next_pc   (wb_next_pc),
        .wb_ebreak    (wb_ebreak),
        .wb_illegal   (wb_illegal),
        .inst         (inst),
        .dnpc         (dnpc),
        .kill         (kill),
        .invalid      (invalid),
        .en           (en),
        .halted       (halted),
        .hang         (hang),
        .retired_count(retired_count),
        .cycle_count  (cycle_count)
    );

    typedef struct {
        logic        valid;
        logic [31:0] in_inst;
        logic [63:0] in_npc;
        logic        ebreak;
        logic        illegal;
        logic        x_en;
        logic [31:0] x_inst;
        logic [63:0] x_dnpc;
        logic        x_kill;
        logic        x_invalid;
        logic        x_halted;
        logic        x_ready;
        logic [63:0] x_retired;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] npc,
                         input logic eb, input logic il);
        wb_valid   = v;
        wb_inst    = i;
        wb_next_pc = npc;
        wb_ebreak  = eb;
        wb_illegal = il;
    endtask

    // Step one edge and leave time 1 unit past it for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0013, 64'h8000_0004, 1'b0, 1'b0,
                    1'b1, 32'h0000_0013, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1};
        vecs[1] = '{1'b1, 32'h0010_0093, 64'h8000_0008, 1'b0, 1'b0,
                    1'b1, 32'h0010_0093, 64'h8000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
        vecs[2] = '{1'b1, 32'h0020_0113, 64'h8000_000c, 1'b0, 1'b0,
                    1'b1, 32'h0020_0113, 64'h8000_000c, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3};
        vecs[3] = '{1'b1, 32'h0010_0073, 64'h8000_0010, 1'b1, 1'b0,
                    1'b1, 32'h0010_0073, 64'h8000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 64'd4};
        vecs[4] = '{1'b1, 32'h0030_0193, 64'h8000_0014, 1'b0, 1'b0,
                    1'b0, 32'h0010_0073, 64'h8000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 64'd4};
        vecs[5] = '{1'b1, 32'h0040_0213, 64'h8000_0018, 1'b0, 1'b0,
                    1'b0, 32'h0010_0073, 64'h8000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 64'd4};

        // Reset values, sampled before any clock edge in RUN.
        do_reset();
        #1;
        chk("rst_en", en, 0);
        chk("rst_ready", wb_ready, 1);
        chk("rst_halted", halted, 0);
        chk("rst_hang", hang, 0);
        chk("rst_inst", inst, 0);
        chk("rst_dnpc", dnpc, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_cycles", cycle_count, 0);

        // Back-to-back commits, then ebreak with wb_valid held.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].in_inst, vecs[i].in_npc, vecs[i].ebreak,
                  vecs[i].illegal);
            step();
            chk($sformatf("v%0d_en", i), en, vecs[i].x_en);
            chk($sformatf("v%0d_inst", i), inst, vecs[i].x_inst);
            chk($sformatf("v%0d_dnpc", i), dnpc, vecs[i].x_dnpc);
            chk($sformatf("v%0d_kill", i), kill, vecs[i].x_kill);
            chk($sformatf("v%0d_invalid", i), invalid, vecs[i].x_invalid);
            chk($sformatf("v%0d_halted", i), halted, vecs[i].x_halted);
            chk($sformatf("v%0d_ready", i), wb_ready, vecs[i].x_ready);
            chk($sformatf("v%0d_retired", i), retired_count, vecs[i].x_retired);
        end
        chk("ebreak_hang", hang, 0);
        chk("ebreak_cycles", cycle_count, 4);

        // ebreak together with illegal: invalid wins.
        do_reset();
        drive(1'b1, 32'h0010_0073, 64'h8000_0004, 1'b1, 1'b1);
        step();
        chk("both_en", en, 1);
        chk("both_invalid", invalid, 1);
        chk("both_kill", kill, 0);
        chk("both_halted", halted, 1);
        chk("both_hang", hang, 0);
        step();
        chk("both_en_after", en, 0);
        chk("both_ready_after", wb_ready, 0);

        // Misaligned next PC.
        do_reset();
        drive(1'b1, 32'h0000_0013, 64'h8000_0006, 1'b0, 1'b0);
        step();
        chk("mis_invalid", invalid, 1);
        chk("mis_kill", kill, 0);
        chk("mis_halted", halted, 1);
        chk("mis_dnpc", dnpc, 64'h8000_0006);

        // Watchdog expiry with no commits.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("wd_idle%0d_hang", i), hang, 0);
        end
        step();
        chk("wd_hang", hang, 1);
        chk("wd_halted", halted, 1);
        chk("wd_en", en, 0);
        chk("wd_cycles", cycle_count, 8);
        step();
        chk("wd_cycles_frozen", cycle_count, 8);

        // Commit in the would-expire cycle, then the watchdog restarts.
        do_reset();
        for (int i = 0; i < 7; i++) step();
        drive(1'b1, 32'h0000_0013, 64'h8000_0004, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("wdc_hang", hang, 0);
        chk("wdc_halted", halted, 0);
        chk("wdc_en", en, 1);
        chk("wdc_cycles", cycle_count, 8);
        for (int i = 0; i < 7; i++) step();
        chk("wdc_restart_nohang", hang, 0);
        step();
        chk("wdc_restart_hang", hang, 1);
        chk("wdc_restart_cycles", cycle_count, 16);
        chk("wdc_retired", retired_count, 1);

        // Asynchronous reset mid-run.
        do_reset();
        drive(1'b1, 32'h0000_0013, 64'h8000_0004, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h0010_0073, 64'h8000_0008, 1'b1, 1'b0);
        step();
        chk("ar_pre_halted", halted, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_en", en, 0);
        chk("ar_inst", inst, 0);
        chk("ar_dnpc", dnpc, 0);
        chk("ar_kill", kill, 0);
        chk("ar_halted", halted, 0);
        chk("ar_ready", wb_ready, 1);
        chk("ar_retired", retired_count, 0);
        chk("ar_cycles", cycle_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0000_0093, 64'h8000_0100, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("ar_post_ready", wb_ready, 1);
        chk("ar_post_retired", retired_count, 1);
        chk("ar_post_cycles", cycle_count, 1);
        chk("ar_post_dnpc", dnpc, 64'h8000_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
